// File: rtl/spi_pkg.sv
// ============================================================================
// Module   : spi_pkg
// Purpose  : Shared state encodings, speed presets and MISO-sampling limits for
//            the SPI byte master. Optional macro: SPI_MISO_SYNC_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package spi_pkg;

  localparam int SPI_DATA_W = 8;
  localparam int SPI_DIV_W  = 12;

  localparam logic [11:0] SPI_SPEED_CORE = 12'd1;
  localparam logic [11:0] SPI_SPEED_IO   = 12'd40;

  typedef logic [1:0] spi_state_t;

  localparam spi_state_t ST_IDLE   = 2'd0;
  localparam spi_state_t ST_SCK_LO = 2'd1;
  localparam spi_state_t ST_SCK_HI = 2'd2;
  localparam spi_state_t ST_DONE   = 2'd3;

`ifdef SPI_MISO_SYNC_EN
  // Two synchroniser flops must settle inside one SCK high phase.
  localparam int SPI_MIN_HALF = 3;
`else
  localparam int SPI_MIN_HALF = 1;
`endif

endpackage

`default_nettype wire

// File: rtl/spi_half_period_timer.sv
// ============================================================================
// Module   : spi_half_period_timer
// Purpose  : Latches the SCK half-period at load and ticks on the last cycle of
//            each half-period while running. Optional macro: SPI_MISO_SYNC_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_half_period_timer
  import spi_pkg::*;
#(
  parameter int DIV_W = SPI_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_run,
  input  logic [DIV_W-1:0] i_divisor,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_half;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_half;

  assign w_half = (i_divisor < DIV_W'(SPI_MIN_HALF)) ? DIV_W'(SPI_MIN_HALF) : i_divisor;
  assign o_tick = i_run && (r_cnt == (r_half - DIV_W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_half <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_half <= w_half;
      r_cnt  <= '0;
    end else if (i_run) begin
      r_cnt  <= o_tick ? '0 : r_cnt + DIV_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_byte_master.sv
// ============================================================================
// Module   : spi_byte_master
// Purpose  : Mode-0, MSB-first SPI byte engine with a 4-phase tx_go/tx_done
//            handshake. Optional macro: SPI_MISO_SYNC_EN (synchronised MISO).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_byte_master
  import spi_pkg::*;
#(
  parameter int DIV_W  = SPI_DIV_W,
  parameter int DATA_W = SPI_DATA_W
) (
  input  logic              clk_in,
  input  logic              n_reset,
  input  logic [DIV_W-1:0]  divisor,
  input  logic              tx_go,
  output logic              tx_done,
  input  logic [DATA_W-1:0] tx_buffer,
  output logic [DATA_W-1:0] rx_buffer,
  output logic              busy,
  output logic              spi_sck,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  spi_state_t        r_state;
  spi_state_t        w_state_nxt;

  logic              r_tx_done,  w_tx_done_nxt;
  logic              r_busy,     w_busy_nxt;
  logic              r_sck,      w_sck_nxt;
  logic              r_mosi,     w_mosi_nxt;
  logic [DATA_W-1:0] r_rx,       w_rx_nxt;
  logic [DATA_W-1:0] r_shreg,    w_shreg_nxt;
  logic [BIT_W-1:0]  r_bit_cnt,  w_bit_cnt_nxt;

  logic              w_start;
  logic              w_run;
  logic              w_tick;
  logic              w_rx_bit;

  assign w_start = (r_state == ST_IDLE) && tx_go && !r_tx_done;
  assign w_run   = (r_state == ST_SCK_LO) || (r_state == ST_SCK_HI);

  spi_half_period_timer #(
    .DIV_W (DIV_W)
  ) u_timer (
    .clk       (clk_in),
    .rst_n     (n_reset),
    .i_load    (w_start),
    .i_run     (w_run),
    .i_divisor (divisor),
    .o_tick    (w_tick)
  );

`ifdef SPI_MISO_SYNC_EN
  // Synchronised bit is consumed at the end of the SCK high phase.
  logic r_miso_s1, r_miso_s2;

  always_ff @(posedge clk_in or negedge n_reset) begin
    if (!n_reset) begin
      r_miso_s1 <= 1'b0;
      r_miso_s2 <= 1'b0;
    end else begin
      r_miso_s1 <= spi_miso;
      r_miso_s2 <= r_miso_s1;
    end
  end

  assign w_rx_bit = r_miso_s2;
`else
  // Raw MISO captured on the SCK rising transition, consumed on the falling one.
  logic r_miso_bit;

  always_ff @(posedge clk_in or negedge n_reset) begin
    if (!n_reset) begin
      r_miso_bit <= 1'b0;
    end else if ((r_state == ST_SCK_LO) && w_tick) begin
      r_miso_bit <= spi_miso;
    end
  end

  assign w_rx_bit = r_miso_bit;
`endif

  always_ff @(posedge clk_in or negedge n_reset) begin
    if (!n_reset) begin
      r_state   <= ST_IDLE;
      r_tx_done <= 1'b0;
      r_busy    <= 1'b0;
      r_sck     <= 1'b0;
      r_mosi    <= 1'b0;
      r_rx      <= '0;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_tx_done <= w_tx_done_nxt;
      r_busy    <= w_busy_nxt;
      r_sck     <= w_sck_nxt;
      r_mosi    <= w_mosi_nxt;
      r_rx      <= w_rx_nxt;
      r_shreg   <= w_shreg_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_start) w_state_nxt = ST_SCK_LO;
      ST_SCK_LO: if (w_tick)  w_state_nxt = ST_SCK_HI;
      ST_SCK_HI: if (w_tick)  w_state_nxt = (r_bit_cnt == '0) ? ST_DONE : ST_SCK_LO;
      ST_DONE:   if (!tx_go)  w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_tx_done_nxt = r_tx_done;
    w_busy_nxt    = r_busy;
    w_sck_nxt     = r_sck;
    w_mosi_nxt    = r_mosi;
    w_rx_nxt      = r_rx;
    w_shreg_nxt   = r_shreg;
    w_bit_cnt_nxt = r_bit_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_shreg_nxt   = tx_buffer;
          w_mosi_nxt    = tx_buffer[DATA_W-1];
          w_bit_cnt_nxt = BIT_W'(DATA_W - 1);
          w_busy_nxt    = 1'b1;
        end
      end
      ST_SCK_LO: begin
        if (w_tick) w_sck_nxt = 1'b1;
      end
      ST_SCK_HI: begin
        if (w_tick) begin
          w_sck_nxt = 1'b0;
          if (r_bit_cnt == '0) begin
            w_rx_nxt      = {r_shreg[DATA_W-2:0], w_rx_bit};
            w_tx_done_nxt = 1'b1;
          end else begin
            w_shreg_nxt   = {r_shreg[DATA_W-2:0], w_rx_bit};
            w_mosi_nxt    = r_shreg[DATA_W-2];
            w_bit_cnt_nxt = r_bit_cnt - BIT_W'(1);
          end
        end
      end
      ST_DONE: begin
        w_sck_nxt = 1'b0;
        if (!tx_go) begin
          w_tx_done_nxt = 1'b0;
          w_busy_nxt    = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign tx_done   = r_tx_done;
  assign busy      = r_busy;
  assign spi_sck   = r_sck;
  assign spi_mosi  = r_mosi;
  assign rx_buffer = r_rx;

endmodule

`default_nettype wire
